// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: run/step/halt sequencer for a 5-stage pipeline.
// Ports: clk, reset (sync, high); cmd_valid/cmd_op/cmd_ready host
//   command handshake; instruction (IF/ID word, halt detect);
//   fetch_en, pipe_en, pipe_restart, done, state, cycle_count.
// Optional: PIPELINE_CTRL_CYCLE_CNT_EN builds the pipe_en cycle
//   counter; otherwise cycle_count is tied to zero.
module pipeline_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter logic [5:0]  HALT_OPCODE  = 6'h3F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    output logic        cmd_ready,
    input  logic [31:0] instruction,
    output logic        fetch_en,
    output logic        pipe_en,
    output logic        pipe_restart,
    output logic        done,
    output logic [2:0]  state,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_STEP    = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4,
        S_RESTART = 3'd5
    } state_t;

    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int unsigned CNT_W =
        (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    state_t           curState;
    state_t           nextState;
    logic [CNT_W-1:0] drainCnt;
    logic [CNT_W-1:0] drainNext;
    logic             cmdAccept;
    logic             isHalt;
    logic             unusedInstrBits;

    // Only the opcode field matters here.
    assign unusedInstrBits = ^instruction[25:0];

    assign cmdAccept = cmd_valid && cmd_ready;
    assign isHalt    = (instruction[31:26] == HALT_OPCODE);

    always_ff @(posedge clk) begin
        if (reset) begin
            curState <= S_IDLE;
            drainCnt <= '0;
        end else begin
            curState <= nextState;
            drainCnt <= drainNext;
        end
    end

    always_comb begin
        nextState = S_IDLE;
        drainNext = drainCnt;
        unique case (curState)
            S_IDLE: begin
                nextState = S_IDLE;
                if (cmdAccept && cmd_op == OP_RUN) begin
                    nextState = S_RUN;
                end else if (cmdAccept && cmd_op == OP_STEP) begin
                    nextState = S_STEP;
                end
            end
            S_RUN: begin
                // A fetched halt outranks a host HALT in the same cycle.
                if (isHalt) begin
                    nextState = S_DRAIN;
                    drainNext = DRAIN_LOAD;
                end else if (cmdAccept && cmd_op == OP_HALT) begin
                    nextState = S_IDLE;
                end else begin
                    nextState = S_RUN;
                end
            end
            S_STEP: begin
                if (isHalt) begin
                    nextState = S_DRAIN;
                    drainNext = DRAIN_LOAD;
                end else begin
                    nextState = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (drainCnt == '0) begin
                    nextState = S_DONE;
                end else begin
                    nextState = S_DRAIN;
                    drainNext = drainCnt - 1'b1;
                end
            end
            S_DONE: begin
                nextState = S_DONE;
                if (cmdAccept &&
                    (cmd_op == OP_RUN || cmd_op == OP_STEP)) begin
                    nextState = S_RESTART;
                end
            end
            S_RESTART: nextState = S_IDLE;
            default:   nextState = S_IDLE;
        endcase
    end

    // Outputs decode the state register only.
    always_comb begin
        fetch_en     = 1'b0;
        pipe_en      = 1'b0;
        pipe_restart = 1'b0;
        done         = 1'b0;
        cmd_ready    = 1'b0;
        unique case (curState)
            S_IDLE: cmd_ready = 1'b1;
            S_RUN: begin
                fetch_en  = 1'b1;
                pipe_en   = 1'b1;
                cmd_ready = 1'b1;
            end
            S_STEP: begin
                fetch_en = 1'b1;
                pipe_en  = 1'b1;
            end
            S_DRAIN: pipe_en = 1'b1;
            S_DONE: begin
                done      = 1'b1;
                cmd_ready = 1'b1;
            end
            S_RESTART: pipe_restart = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    assign state = curState;

`ifdef PIPELINE_CTRL_CYCLE_CNT_EN
    // Cleared on entry so the count already reads 0 during RESTART.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (nextState == S_RESTART) begin
            cycle_count <= '0;
        end else if (pipe_en && cycle_count != 32'hFFFF_FFFF) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors into a scoreboard queue;
// a monitor pops and compares after every rising edge.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic        cmd_ready;
    logic [31:0] instruction = 32'h0000_0013;
    logic        fetch_en;
    logic        pipe_en;
    logic        pipe_restart;
    logic        done;
    logic [2:0]  state;
    logic [31:0] cycle_count;

    localparam logic [31:0] NH = 32'h0000_0013;
    localparam logic [31:0] HI = 32'hFC00_0000;
    localparam logic [1:0]  NOP = 2'b00;
    localparam logic [1:0]  RUN = 2'b01;
    localparam logic [1:0]  STP = 2'b10;
    localparam logic [1:0]  HLT = 2'b11;

    int vectors = 0;
    int miscompares = 0;

    logic [39:0] expQ[$];
    string       nameQ[$];

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_op(cmd_op),
        .cmd_ready(cmd_ready),
        .instruction(instruction),
        .fetch_en(fetch_en),
        .pipe_en(pipe_en),
        .pipe_restart(pipe_restart),
        .done(done),
        .state(state),
        .cycle_count(cycle_count)
    );

    // Drive one cycle of inputs; expected outputs are those seen
    // after the following rising edge.
    task automatic v(
        input logic        rst,
        input logic        vld,
        input logic [1:0]  op,
        input logic [31:0] ins,
        input logic [2:0]  st,
        input logic        fe,
        input logic        pe,
        input logic        pr,
        input logic        dn,
        input logic        rdy,
        input logic [31:0] cnt,
        input string       name
    );
        logic [31:0] c;
        @(negedge clk);
        reset       = rst;
        cmd_valid   = vld;
        cmd_op      = op;
        instruction = ins;
`ifdef PIPELINE_CTRL_CYCLE_CNT_EN
        c = cnt;
`else
        c = 32'd0;
`endif
        expQ.push_back({st, fe, pe, pr, dn, rdy, c});
        nameQ.push_back(name);
    endtask

    initial begin : monitor
        logic [39:0] exp;
        logic [39:0] act;
        string       nm;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                exp = expQ.pop_front();
                nm  = nameQ.pop_front();
                act = {state, fetch_en, pipe_en, pipe_restart,
                       done, cmd_ready, cycle_count};
                vectors++;
                if (act !== exp) begin
                    miscompares++;
                    $display("FAIL %s: got st=%0d fe=%b pe=%b pr=%b dn=%b rdy=%b cnt=%0d, want st=%0d fe=%b pe=%b pr=%b dn=%b rdy=%b cnt=%0d",
                        nm, act[39:37], act[36], act[35], act[34],
                        act[33], act[32], act[31:0],
                        exp[39:37], exp[36], exp[35], exp[34],
                        exp[33], exp[32], exp[31:0]);
                end
            end
        end
    end

    initial begin : stim
        int guard;
        //  rst vld op  ins  st fe pe pr dn rdy cnt
        v(1, 0, NOP, NH, 0, 0, 0, 0, 0, 1, 0, "reset0");
        v(1, 0, NOP, NH, 0, 0, 0, 0, 0, 1, 0, "reset1");
        v(0, 1, STP, NH, 2, 1, 1, 0, 0, 0, 0, "step1");
        v(0, 0, NOP, NH, 0, 0, 0, 0, 0, 1, 1, "step1_idle");
        v(0, 1, STP, NH, 2, 1, 1, 0, 0, 0, 1, "step2");
        v(0, 0, NOP, NH, 0, 0, 0, 0, 0, 1, 2, "step2_idle");
        v(0, 1, STP, NH, 2, 1, 1, 0, 0, 0, 2, "step3");
        v(0, 0, NOP, NH, 0, 0, 0, 0, 0, 1, 3, "step3_cnt3");
        v(0, 1, HLT, NH, 0, 0, 0, 0, 0, 1, 3, "idle_halt");
        v(0, 1, NOP, NH, 0, 0, 0, 0, 0, 1, 3, "idle_nop");
        v(0, 1, STP, NH, 2, 1, 1, 0, 0, 0, 3, "step4");
        v(0, 1, RUN, NH, 0, 0, 0, 0, 0, 1, 4, "step_ignores_cmd");
        v(0, 1, RUN, NH, 1, 1, 1, 0, 0, 1, 4, "run_accept");
        v(0, 0, NOP, NH, 1, 1, 1, 0, 0, 1, 5, "run_hold");
        v(0, 1, HLT, NH, 0, 0, 0, 0, 0, 1, 6, "run_halt_freeze");
        v(0, 1, RUN, NH, 1, 1, 1, 0, 0, 1, 6, "run_again");
        v(0, 0, NOP, HI, 3, 0, 1, 0, 0, 0, 7, "drain1");
        v(0, 0, NOP, HI, 3, 0, 1, 0, 0, 0, 8, "drain2");
        v(0, 0, NOP, HI, 3, 0, 1, 0, 0, 0, 9, "drain3");
        v(0, 0, NOP, HI, 3, 0, 1, 0, 0, 0, 10, "drain4");
        v(0, 0, NOP, NH, 4, 0, 0, 0, 1, 1, 11, "done");
        v(0, 1, HLT, NH, 4, 0, 0, 0, 1, 1, 11, "done_halt_ign");
        v(0, 1, NOP, NH, 4, 0, 0, 0, 1, 1, 11, "done_nop_ign");
        v(0, 1, RUN, NH, 5, 0, 0, 1, 0, 0, 0, "restart");
        v(0, 1, RUN, NH, 0, 0, 0, 0, 0, 1, 0, "restart_idle");
        v(0, 1, RUN, NH, 1, 1, 1, 0, 0, 1, 0, "rerun");
        v(0, 0, NOP, NH, 1, 1, 1, 0, 0, 1, 1, "rerun_hold");
        v(0, 1, HLT, HI, 3, 0, 1, 0, 0, 0, 2, "drain_wins");
        v(0, 1, HLT, HI, 3, 0, 1, 0, 0, 0, 3, "drain_halt_a");
        v(0, 1, HLT, NH, 3, 0, 1, 0, 0, 0, 4, "drain_halt_b");
        v(0, 0, NOP, NH, 3, 0, 1, 0, 0, 0, 5, "drain_last");
        v(0, 0, NOP, NH, 4, 0, 0, 0, 1, 1, 6, "done2");
        v(0, 1, STP, NH, 5, 0, 0, 1, 0, 0, 0, "restart_step");
        v(0, 0, NOP, NH, 0, 0, 0, 0, 0, 1, 0, "idle3");
        v(0, 1, STP, NH, 2, 1, 1, 0, 0, 0, 0, "step_halt");
        v(0, 0, NOP, HI, 3, 0, 1, 0, 0, 0, 1, "step_to_drain");
        v(0, 0, NOP, HI, 3, 0, 1, 0, 0, 0, 2, "drain_2nd");
        v(1, 0, NOP, HI, 0, 0, 0, 0, 0, 1, 0, "reset_abort");
        v(0, 0, NOP, NH, 0, 0, 0, 0, 0, 1, 0, "post_abort");
        v(0, 1, RUN, NH, 1, 1, 1, 0, 0, 1, 0, "run_post_abort");
        guard = 0;
        while (expQ.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (expQ.size() > 0) begin
            miscompares++;
            $display("FAIL drain_queue: got %0d pending, want 0",
                     expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
